// File: rtl/r16_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// r16_pipe_ctrl_pkg
// Shared definitions for the radix-16 pipeline sequencer:
//   - state_e    : sequencer states (IDLE, ISSUE, DRAIN, DONE)
//   - P_WIDTH_DEFAULT, P_ZERO, P1_ZERO : datapath width default and zero words
//   - idxWidth() : index width helper that never returns zero
// Optional feature macro used by r16_pipe_ctrl: R16_CTRL_PERF_EN
//   (define it to add the perf_cyc / perf_stall counters).
// ---------------------------------------------------------------------------
package r16_pipe_ctrl_pkg;

  localparam int P_WIDTH_DEFAULT = 64;
  localparam logic [P_WIDTH_DEFAULT-1:0] P_ZERO  = '0;
  localparam logic [P_WIDTH_DEFAULT:0]   P1_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // A one-entry range still needs a one-bit index so port widths stay legal
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/r16_valid_delay.sv
// ---------------------------------------------------------------------------
// r16_valid_delay
// DEPTH-deep 1-bit shift register that mirrors the datapath latency so the
// result-valid flag lines up with the data leaving the R16 pipe registers.
// It has no enable because the pipe registers it tracks have none.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low clear
//   valid_i : issue strobe entering the pipe
//   valid_o : strobe delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module r16_valid_delay
  import r16_pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic valid_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift the issue strobe one stage per cycle; reset discards in-flight valids
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign valid_o = sr_q[DEPTH-1];

endmodule

// File: rtl/r16_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// r16_pipe_ctrl
// Sequencer for the radix-16 butterfly pipeline. On an accepted start it
// issues STG_NUM stages of 2^GRP_WIDTH butterfly groups, inserting a
// PIPE_DEPTH-cycle drain after each stage so results land before the next
// stage reads them, then pulses done for one cycle.
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   start           : transform request, accepted only in IDLE
//   inverse         : inverse flag, latched with an accepted start
//   ninv2_cfg       : N^-1/2 scaling word, latched with an accepted start
//   stall           : upstream not ready, suppresses issue in ISSUE only
//   busy            : high in ISSUE and DRAIN
//   issue_valid     : butterfly group issued this cycle
//   stage_idx       : current stage
//   grp_idx         : current group within the stage
//   Ninv2_out       : latched scaling word on final inverse-stage issues, else 0
//   out_valid       : issue_valid delayed PIPE_DEPTH cycles
//   done            : one-cycle completion pulse
//   perf_cyc        : busy-cycle counter     (only with R16_CTRL_PERF_EN)
//   perf_stall      : stalled-issue counter  (only with R16_CTRL_PERF_EN)
// Optional feature macro: R16_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module r16_pipe_ctrl
  import r16_pipe_ctrl_pkg::*;
#(
  parameter int P_WIDTH    = P_WIDTH_DEFAULT,
  parameter int STG_NUM    = 3,
  parameter int GRP_WIDTH  = 8,
  parameter int PIPE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             inverse,
  input  logic [P_WIDTH:0]                 ninv2_cfg,
  input  logic                             stall,
  output logic                             busy,
  output logic                             issue_valid,
  output logic [idxWidth(STG_NUM)-1:0]     stage_idx,
  output logic [GRP_WIDTH-1:0]             grp_idx,
  output logic [P_WIDTH:0]                 Ninv2_out,
  output logic                             out_valid,
  output logic                             done
`ifdef R16_CTRL_PERF_EN
  ,
  output logic [31:0]                      perf_cyc,
  output logic [31:0]                      perf_stall
`endif
);

  localparam int SW = idxWidth(STG_NUM);
  localparam int DW = idxWidth(PIPE_DEPTH);
  localparam logic [SW-1:0]        LAST_STG = SW'(STG_NUM - 1);
  localparam logic [GRP_WIDTH-1:0] LAST_GRP = '1;
  localparam logic [DW-1:0]        LAST_DRN = DW'(PIPE_DEPTH - 1);

  state_e                 state_q, state_d;
  logic [GRP_WIDTH-1:0]   grp_q, grp_d;
  logic [SW-1:0]          stage_q, stage_d;
  logic [DW-1:0]          drn_q, drn_d;
  logic                   inv_q, inv_d;
  logic [P_WIDTH:0]       ninv_q, ninv_d;

  logic accept, issue, grpLast, drnLast, stgLast;

  assign accept  = (state_q == IDLE) && start;
  assign issue   = (state_q == ISSUE) && !stall;
  assign grpLast = (grp_q == LAST_GRP);
  assign drnLast = (drn_q == LAST_DRN);
  assign stgLast = (stage_q == LAST_STG);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a stage ends on its last issue, the drain always runs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (issue && grpLast) state_d = DRAIN;
      DRAIN:   if (drnLast) state_d = stgLast ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state; issue is the only stall-dependent term
  always_comb begin
    busy        = (state_q == ISSUE) || (state_q == DRAIN);
    done        = (state_q == DONE);
    issue_valid = issue;
    Ninv2_out   = (P_WIDTH + 1)'(P1_ZERO);
    if (issue && inv_q && stgLast) begin
      Ninv2_out = ninv_q;
    end
  end

  // Counter and latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q   <= '0;
      stage_q <= '0;
      drn_q   <= '0;
      inv_q   <= 1'b0;
      ninv_q  <= (P_WIDTH + 1)'({1'b0, P_ZERO});
    end else begin
      grp_q   <= grp_d;
      stage_q <= stage_d;
      drn_q   <= drn_d;
      inv_q   <= inv_d;
      ninv_q  <= ninv_d;
    end
  end

  // Counter updates: grp wraps to 0 naturally after its last group, and the
  // stage index returns to 0 once the final drain completes
  always_comb begin
    grp_d   = grp_q;
    stage_d = stage_q;
    drn_d   = drn_q;
    inv_d   = inv_q;
    ninv_d  = ninv_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          grp_d   = '0;
          stage_d = '0;
          drn_d   = '0;
          inv_d   = inverse;
          ninv_d  = ninv2_cfg;
        end
      end
      ISSUE: begin
        drn_d = '0;
        if (issue) grp_d = grp_q + 1'b1;
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (drnLast) begin
          drn_d   = '0;
          grp_d   = '0;
          stage_d = stgLast ? '0 : stage_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign stage_idx = stage_q;
  assign grp_idx   = grp_q;

  r16_valid_delay #(
    .DEPTH (PIPE_DEPTH)
  ) u_valid_delay (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .valid_i (issue),
    .valid_o (out_valid)
  );

`ifdef R16_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d, stl_q, stl_d;

  // Performance counters: cleared on accepted start, saturating, hold when idle
  always_comb begin
    cyc_d = cyc_q;
    stl_d = stl_q;
    if (accept) begin
      cyc_d = '0;
      stl_d = '0;
    end else begin
      if (busy && (cyc_q != '1)) cyc_d = cyc_q + 1'b1;
      if ((state_q == ISSUE) && stall && (stl_q != '1)) stl_d = stl_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      stl_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      stl_q <= stl_d;
    end
  end

  assign perf_cyc   = cyc_q;
  assign perf_stall = stl_q;
`else
  logic unusedAccept;
  assign unusedAccept = accept;
`endif

endmodule

// File: tb/tb_r16_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_r16_pipe_ctrl
// Self-checking bench for r16_pipe_ctrl with STG_NUM=2, GRP_WIDTH=2,
// PIPE_DEPTH=4. A schedule builder derives the expected per-cycle outputs
// from the stall pattern: each stage issues G groups on unstalled cycles,
// then drains for PIPE_DEPTH cycles; done follows the last drain.
// Optional feature macro: R16_CTRL_PERF_EN (adds perf counter checks).
// ---------------------------------------------------------------------------
module tb_r16_pipe_ctrl;

  localparam int STG  = 2;
  localparam int GW   = 2;
  localparam int PD   = 4;
  localparam int PW   = 64;
  localparam int G    = 1 << GW;
  localparam int MAXC = 96;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          inverse;
  logic [PW:0]   ninv2_cfg;
  logic          stall;
  logic          busy;
  logic          issue_valid;
  logic [0:0]    stage_idx;
  logic [GW-1:0] grp_idx;
  logic [PW:0]   Ninv2_out;
  logic          out_valid;
  logic          done;
`ifdef R16_CTRL_PERF_EN
  logic [31:0]   perf_cyc;
  logic [31:0]   perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference schedule
  bit          stallPat [MAXC];
  bit          expIssue [MAXC];
  bit          expBusy  [MAXC];
  bit          expDone  [MAXC];
  bit          expOv    [MAXC];
  int          expStage [MAXC];
  int          expGrp   [MAXC];
  int          lastCycle;
  int          expCyc;
  int          expStl;
  bit          refInv;
  logic [PW:0] refNinv;

  r16_pipe_ctrl #(
    .P_WIDTH    (PW),
    .STG_NUM    (STG),
    .GRP_WIDTH  (GW),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .inverse     (inverse),
    .ninv2_cfg   (ninv2_cfg),
    .stall       (stall),
    .busy        (busy),
    .issue_valid (issue_valid),
    .stage_idx   (stage_idx),
    .grp_idx     (grp_idx),
    .Ninv2_out   (Ninv2_out),
    .out_valid   (out_valid),
    .done        (done)
`ifdef R16_CTRL_PERF_EN
    ,
    .perf_cyc    (perf_cyc),
    .perf_stall  (perf_stall)
`endif
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Build expected outputs for a transform whose start is seen in cycle 0
  function automatic void buildSchedule();
    int c;
    int g;
    for (int i = 0; i < MAXC; i++) begin
      expIssue[i] = 0; expBusy[i] = 0; expDone[i] = 0; expOv[i] = 0;
      expStage[i] = 0; expGrp[i] = 0;
    end
    c = 1; expCyc = 0; expStl = 0;
    for (int s = 0; s < STG; s++) begin
      g = 0;
      while (g < G) begin
        expBusy[c] = 1; expStage[c] = s; expGrp[c] = g;
        if (stallPat[c]) expStl++;
        else begin expIssue[c] = 1; g++; end
        expCyc++; c++;
      end
      for (int d = 0; d < PD; d++) begin
        expBusy[c] = 1; expStage[c] = s; expGrp[c] = 0;
        expCyc++; c++;
      end
    end
    expDone[c] = 1;
    lastCycle = c;
    for (int i = PD; i < MAXC; i++) expOv[i] = expIssue[i-PD];
  endfunction

  function automatic logic [8:0] expCtrl(input int c);
    return {expIssue[c], expBusy[c], expDone[c], expOv[c], 1'(expStage[c]), GW'(expGrp[c])};
  endfunction

  function automatic logic [PW:0] expNinv(input int c);
    return (expIssue[c] && refInv && expStage[c] == STG - 1) ? refNinv : '0;
  endfunction

  function automatic logic [PW:0] randWord();
    return (PW + 1)'({$urandom, $urandom, $urandom});
  endfunction

  // Advance to just after the next rising edge and drive this cycle's inputs
  task automatic applyStimulus(input bit s, input bit st);
    @(posedge clk);
    #1;
    start = s;
    stall = st;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; inverse = 0; stall = 0; ninv2_cfg = '0;
    #3;
    checks++;
    if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b want %b", {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, 9'd0);
    end
    checks++;
    if (Ninv2_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ninv: got %h want 0", Ninv2_out);
    end
`ifdef R16_CTRL_PERF_EN
    checks++;
    if ({perf_cyc, perf_stall} !== 64'd0) begin
      failures++;
      $display("[TB] FAIL reset_perf: got %0d/%0d want 0/0", perf_cyc, perf_stall);
    end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_forward();
    for (int i = 0; i < MAXC; i++) stallPat[i] = 0;
    refInv = 0; refNinv = randWord();
    buildSchedule();
    applyStimulus(1, 0);
    inverse = 0; ninv2_cfg = refNinv;
    for (int c = 0; c <= lastCycle + 2; c++) begin
      if (c > 0) applyStimulus(0, stallPat[c]);
      @(negedge clk);
      checks++;
      if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx} !== expCtrl(c)) begin
        failures++;
        $display("[TB] FAIL fwd_ctrl cycle %0d: got %b want %b", c, {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, expCtrl(c));
      end
      checks++;
      if (Ninv2_out !== expNinv(c)) begin
        failures++;
        $display("[TB] FAIL fwd_ninv cycle %0d: got %h want %h", c, Ninv2_out, expNinv(c));
      end
    end
  endtask

  task automatic test_inverse();
    for (int i = 0; i < MAXC; i++) stallPat[i] = 0;
    refInv = 1; refNinv = 65'h0_8000_0000_0000_0000;
    buildSchedule();
    applyStimulus(1, 0);
    inverse = 1; ninv2_cfg = refNinv;
    for (int c = 0; c <= lastCycle + 2; c++) begin
      if (c > 0) begin
        applyStimulus(0, stallPat[c]);
        ninv2_cfg = randWord();
        inverse   = 1'($urandom);
      end
      @(negedge clk);
      checks++;
      if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx} !== expCtrl(c)) begin
        failures++;
        $display("[TB] FAIL inv_ctrl cycle %0d: got %b want %b", c, {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, expCtrl(c));
      end
      checks++;
      if (Ninv2_out !== expNinv(c)) begin
        failures++;
        $display("[TB] FAIL inv_ninv cycle %0d: got %h want %h", c, Ninv2_out, expNinv(c));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < MAXC; i++) stallPat[i] = 0;
    stallPat[2] = 1; stallPat[3] = 1; stallPat[8] = 1; stallPat[15] = 1; stallPat[16] = 1;
    refInv = 1; refNinv = randWord();
    buildSchedule();
    applyStimulus(1, 0);
    inverse = 1; ninv2_cfg = refNinv;
    for (int c = 0; c <= lastCycle + 2; c++) begin
      if (c > 0) applyStimulus(0, stallPat[c]);
      @(negedge clk);
      checks++;
      if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx} !== expCtrl(c)) begin
        failures++;
        $display("[TB] FAIL stall_ctrl cycle %0d: got %b want %b", c, {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, expCtrl(c));
      end
      checks++;
      if (Ninv2_out !== expNinv(c)) begin
        failures++;
        $display("[TB] FAIL stall_ninv cycle %0d: got %h want %h", c, Ninv2_out, expNinv(c));
      end
    end
`ifdef R16_CTRL_PERF_EN
    checks++;
    if (perf_cyc !== 32'(expCyc) || perf_stall !== 32'(expStl)) begin
      failures++;
      $display("[TB] FAIL stall_perf: got %0d/%0d want %0d/%0d", perf_cyc, perf_stall, expCyc, expStl);
    end
`endif
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < MAXC; i++) stallPat[i] = (i < 40) && ($urandom_range(0, 2) == 0);
      refInv = 1'($urandom); refNinv = randWord();
      buildSchedule();
      applyStimulus(1, stallPat[0]);
      inverse = refInv; ninv2_cfg = refNinv;
      for (int c = 0; c <= lastCycle + 1; c++) begin
        if (c > 0) begin
          applyStimulus(0, stallPat[c]);
          ninv2_cfg = randWord();
        end
        @(negedge clk);
        checks++;
        if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx} !== expCtrl(c)) begin
          failures++;
          $display("[TB] FAIL rand_ctrl run %0d cycle %0d: got %b want %b", r, c, {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, expCtrl(c));
        end
        checks++;
        if (Ninv2_out !== expNinv(c)) begin
          failures++;
          $display("[TB] FAIL rand_ninv run %0d cycle %0d: got %h want %h", r, c, Ninv2_out, expNinv(c));
        end
      end
`ifdef R16_CTRL_PERF_EN
      checks++;
      if (perf_cyc !== 32'(expCyc) || perf_stall !== 32'(expStl)) begin
        failures++;
        $display("[TB] FAIL rand_perf run %0d: got %0d/%0d want %0d/%0d", r, perf_cyc, perf_stall, expCyc, expStl);
      end
`endif
    end
  endtask

  // Starts during ISSUE/DRAIN and DONE are dropped; the one right after DONE runs
  task automatic test_back_to_back();
    int e;
    bit s;
    for (int i = 0; i < MAXC; i++) stallPat[i] = 0;
    refInv = 0; refNinv = '0;
    buildSchedule();
    applyStimulus(1, 0);
    inverse = 0; ninv2_cfg = randWord();
    for (int c = 0; c <= 2 * lastCycle + 2; c++) begin
      s = (c == 5) || (c == lastCycle) || (c == lastCycle + 1);
      if (c > 0) applyStimulus(s, 0);
      e = (c <= lastCycle) ? c : c - (lastCycle + 1);
      @(negedge clk);
      checks++;
      if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx} !== expCtrl(e)) begin
        failures++;
        $display("[TB] FAIL b2b_ctrl cycle %0d: got %b want %b", c, {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, expCtrl(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < MAXC; i++) stallPat[i] = 0;
    refInv = 1; refNinv = randWord();
    buildSchedule();
    applyStimulus(1, 0);
    inverse = 1; ninv2_cfg = refNinv;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) applyStimulus(0, 0);
      @(negedge clk);
      checks++;
      if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx} !== expCtrl(c)) begin
        failures++;
        $display("[TB] FAIL rmid_pre cycle %0d: got %b want %b", c, {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, expCtrl(c));
      end
    end
    applyStimulus(0, 0);
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) applyStimulus(0, 0);
      #1;
      checks++;
      if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx, Ninv2_out} !== '0) begin
        failures++;
        $display("[TB] FAIL rmid_reset step %0d: got %b/%h want all zero", k, {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, Ninv2_out);
      end
    end
    applyStimulus(0, 0);
    rst_n = 1'b1;
    refInv = 0; refNinv = randWord();
    applyStimulus(1, 0);
    inverse = 0; ninv2_cfg = refNinv;
    for (int c = 0; c <= lastCycle + 1; c++) begin
      if (c > 0) applyStimulus(0, 0);
      @(negedge clk);
      checks++;
      if ({issue_valid, busy, done, out_valid, stage_idx, grp_idx} !== expCtrl(c)) begin
        failures++;
        $display("[TB] FAIL rmid_post cycle %0d: got %b want %b", c, {issue_valid, busy, done, out_valid, stage_idx, grp_idx}, expCtrl(c));
      end
      checks++;
      if (Ninv2_out !== expNinv(c)) begin
        failures++;
        $display("[TB] FAIL rmid_ninv cycle %0d: got %h want %h", c, Ninv2_out, expNinv(c));
      end
    end
  endtask

  // Run all scenarios back to back and report
  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_stall();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
